ahbl_master_mux: RTL and testbench

//  2-master to 1-slave AHB-Lite arbiter/multiplexer, the upstream counterpart of the bus splitter.

---
 rtl/ahbl_master_mux.sv | 149 ++++++++++++++
 tb/tb_ahbl_master_mux.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_master_mux.sv
// Two-master to one-slave AHB-Lite arbiter/multiplexer with burst lock and deferred data-phase completion.
// Define AHBL_MUX_RR_EN for round-robin arbitration; fixed priority (M0 wins) otherwise.
module ahbl_master_mux #(
  parameter int PARK = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HWRITE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HWRITE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA
);

  localparam logic [1:0] HT_BUSY = 2'b01;
  localparam logic [1:0] HT_SEQ  = 2'b11;
  localparam logic       PARK_M  = (PARK != 0);

  logic        addr_own_q, addr_own_d;
  logic        data_act_q, data_act_d;
  logic        data_own_q, data_own_d;
  logic [1:0]  pend_q, pend_d;
  logic [31:0] hold0_q, hold0_d;
  logic [31:0] hold1_q, hold1_d;

  logic [1:0]  req;
  logic [1:0]  own_trans;
  logic        lock;
  logic        nxt;
  logic [1:0]  granted;
  logic [1:0]  in_data;
  logic [1:0]  accept;
  logic [1:0]  defer;

  // Ready seen by one master, in priority order: pending, data phase, request, idle.
  function automatic logic master_ready(input logic pend, input logic data_ph,
                                        input logic rq, input logic gnt,
                                        input logic bus_rdy);
    logic rdy;
    if (pend)         rdy = gnt & bus_rdy;
    else if (data_ph) rdy = bus_rdy & (~rq | gnt);
    else if (rq)      rdy = gnt & bus_rdy;
    else              rdy = 1'b1;
    return rdy;
  endfunction

  always_comb begin
    req       = {M1_HTRANS[1], M0_HTRANS[1]};
    own_trans = addr_own_q ? M1_HTRANS : M0_HTRANS;
    lock      = (own_trans == HT_SEQ) || (own_trans == HT_BUSY);
  end

  always_comb begin
    nxt = addr_own_q;
    if (lock) begin
      nxt = addr_own_q;
    end else if (req == 2'b01) begin
      nxt = 1'b0;
    end else if (req == 2'b10) begin
      nxt = 1'b1;
    end else if (req == 2'b11) begin
`ifdef AHBL_MUX_RR_EN
      nxt = ~addr_own_q;
`else
      nxt = 1'b0;
`endif
    end
  end

  // Address phase passes straight through from the granted master.
  always_comb begin
    HADDR  = nxt ? M1_HADDR  : M0_HADDR;
    HTRANS = nxt ? M1_HTRANS : M0_HTRANS;
    HSIZE  = nxt ? M1_HSIZE  : M0_HSIZE;
    HWRITE = nxt ? M1_HWRITE : M0_HWRITE;
    HWDATA = data_own_q ? M1_HWDATA : M0_HWDATA;
  end

  always_comb begin
    granted = {nxt, ~nxt};
    in_data = {data_act_q & data_own_q, data_act_q & ~data_own_q};
    accept  = granted & {2{HREADY}};
    defer   = {2{HREADY}} & in_data & req & ~granted;
  end

  always_comb begin
    M0_HREADY = master_ready(pend_q[0], in_data[0], req[0], granted[0], HREADY);
    M1_HREADY = master_ready(pend_q[1], in_data[1], req[1], granted[1], HREADY);
    M0_HRDATA = pend_q[0] ? hold0_q : HRDATA;
    M1_HRDATA = pend_q[1] ? hold1_q : HRDATA;
  end

  // A master that retires a data phase while losing its next address phase keeps
  // the read data aside until its address is finally accepted.
  always_comb begin
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    data_act_d = data_act_q;
    pend_d     = pend_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    if (HREADY) begin
      addr_own_d = nxt;
      data_own_d = nxt;
      data_act_d = req[nxt];
    end
    for (int x = 0; x < 2; x++) begin
      if (defer[x])       pend_d[x] = 1'b1;
      else if (accept[x]) pend_d[x] = 1'b0;
    end
    if (defer[0]) hold0_d = HRDATA;
    if (defer[1]) hold1_d = HRDATA;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_own_q <= PARK_M;
      data_act_q <= 1'b0;
      data_own_q <= 1'b0;
      pend_q     <= 2'b00;
      hold0_q    <= 32'h0;
      hold1_q    <= 32'h0;
    end else begin
      addr_own_q <= addr_own_d;
      data_act_q <= data_act_d;
      data_own_q <= data_own_d;
      pend_q     <= pend_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
    end
  end

endmodule

// File: tb/tb_ahbl_master_mux.sv
// Directed bench for ahbl_master_mux; read data expectations flow through a scoreboard queue.
module tb_ahbl_master_mux;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;
`ifdef AHBL_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HWRITE, M1_HWRITE;
  logic        M0_HREADY, M1_HREADY;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, HREADY;

  int checks = 0;
  int errors = 0;
  logic [31:0] rdq[$];
  logic        m_ao;
  logic        exp_nxt;
  logic        rdy;

  always #5 HCLK = ~HCLK;

  ahbl_master_mux #(.PARK(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
    .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
    .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [31:0] obs);
    if (rdq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      chk(tag, obs, rdq.pop_front());
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle before checks.
  task automatic drv(input logic rst,
                     input logic [1:0] t0, input logic [31:0] a0, input logic w0, input logic [31:0] wd0,
                     input logic [1:0] t1, input logic [31:0] a1, input logic w1, input logic [31:0] wd1,
                     input logic rd_rdy, input logic [31:0] rd);
    @(negedge HCLK);
    HRESET    = rst;
    M0_HTRANS = t0; M0_HADDR = a0; M0_HWRITE = w0; M0_HWDATA = wd0;
    M1_HTRANS = t1; M1_HADDR = a1; M1_HWRITE = w1; M1_HWDATA = wd1;
    HREADY    = rd_rdy;
    HRDATA    = rd;
    #1;
  endtask

  initial begin
    HRESET = 1'b1;
    M0_HADDR = 32'h0; M0_HTRANS = TI; M0_HWRITE = 1'b0; M0_HWDATA = 32'h0;
    M1_HADDR = 32'h0; M1_HTRANS = TI; M1_HWRITE = 1'b0; M1_HWDATA = 32'h0;
    M0_HSIZE = 3'd2; M1_HSIZE = 3'd1;
    HREADY = 1'b1; HRDATA = 32'h0;

    drv(1, TI, 32'hDEAD0000, 0, 0, TI, 32'hBEEF0000, 0, 0, 1, 32'h77);
    chk("rst_m0_hready", M0_HREADY, 1);
    chk("rst_m1_hready", M1_HREADY, 1);
    chk("rst_htrans", HTRANS, TI);
    chk("rst_haddr", HADDR, 32'hDEAD0000);
    drv(0, TI, 32'hDEAD0000, 0, 0, TI, 32'hBEEF0000, 0, 0, 1, 32'h77);

    // reset in the middle of an M1 burst
    drv(0, TI, 32'hDEAD0000, 0, 0, TN, 32'h100, 0, 0, 1, 0);
    chk("burst_nonseq_haddr", HADDR, 32'h100);
    drv(0, TI, 32'hDEAD0000, 0, 0, TS, 32'h104, 0, 0, 1, 0);
    chk("burst_seq_haddr", HADDR, 32'h104);
    chk("burst_seq_htrans", HTRANS, TS);
    drv(1, TI, 32'hDEAD0000, 0, 0, TI, 32'hBEEF0000, 0, 0, 1, 32'h77);
    chk("midrst_htrans", HTRANS, TI);
    chk("midrst_haddr_park", HADDR, 32'hDEAD0000);
    chk("midrst_m0_hready", M0_HREADY, 1);
    chk("midrst_m1_hready", M1_HREADY, 1);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 0);

    // reset while M1 holds a deferred completion
    drv(0, TI, 32'h0, 0, 0, TN, 32'h400, 0, 0, 1, 0);
    chk("pend_setup_m1_hready", M1_HREADY, 1);
    drv(0, TN, 32'h500, 0, 0, TN, 32'h404, 0, 0, 1, 32'h5555AAAA);
    chk("pend_setup_m1_stall", M1_HREADY, 0);
    chk("pend_setup_haddr", HADDR, 32'h500);
    drv(1, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 32'h77);
    chk("rst_pend_m1_hrdata", M1_HRDATA, 32'h77);
    chk("rst_pend_m1_hready", M1_HREADY, 1);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 0);

    // single reads pass through with zero added address latency
    drv(0, TN, 32'h10, 0, 0, TI, 32'h0, 0, 0, 1, 0);
    chk("m0_rd_haddr", HADDR, 32'h10);
    chk("m0_rd_htrans", HTRANS, TN);
    chk("m0_rd_hwrite", HWRITE, 0);
    chk("m0_rd_hsize", HSIZE, 3'd2);
    chk("m0_rd_hready", M0_HREADY, 1);
    rdq.push_back(32'h12345678);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 32'h12345678);
    chk("m0_rd_data_hready", M0_HREADY, 1);
    chk_pop("m0_rd_hrdata", M0_HRDATA);
    chk("m0_rd_idle_htrans", HTRANS, TI);
    drv(0, TI, 32'h0, 0, 0, TN, 32'h40, 0, 0, 1, 0);
    chk("m1_rd_haddr", HADDR, 32'h40);
    chk("m1_rd_hsize", HSIZE, 3'd1);
    chk("m1_rd_hready", M1_HREADY, 1);
    chk("m1_rd_m0_hready", M0_HREADY, 1);
    rdq.push_back(32'hBEEF0040);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h44, 0, 0, 1, 32'hBEEF0040);
    chk_pop("m1_rd_hrdata", M1_HRDATA);
    chk("park_m1_haddr", HADDR, 32'h44);

    // contested request: M0 first, M1 granted once M0 goes idle
    drv(0, TN, 32'h20, 1, 0, TN, 32'h30, 0, 0, 1, 0);
    chk("contest_haddr", HADDR, 32'h20);
    chk("contest_hwrite", HWRITE, 1);
    chk("contest_m0_hready", M0_HREADY, 1);
    chk("contest_m1_hready", M1_HREADY, 0);
    drv(0, TI, 32'h0, 0, 32'hA5A50000, TN, 32'h30, 0, 32'h5A5A0000, 1, 0);
    chk("contest_hwdata_m0", HWDATA, 32'hA5A50000);
    chk("contest_m1_haddr", HADDR, 32'h30);
    chk("contest_m1_granted", M1_HREADY, 1);
    rdq.push_back(32'hC0DE0030);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h30, 0, 32'h11111111, 1, 32'hC0DE0030);
    chk_pop("contest_m1_hrdata", M1_HRDATA);
    chk("contest_hwdata_m1", HWDATA, 32'h11111111);

    // M1 INCR burst with a BUSY beat locks out M0
    drv(0, TI, 32'h0, 0, 0, TN, 32'h200, 0, 0, 1, 0);
    chk("lock_b0_haddr", HADDR, 32'h200);
    chk("lock_b0_m1_hready", M1_HREADY, 1);
    drv(0, TN, 32'h80, 0, 0, TS, 32'h204, 0, 0, 1, 0);
    chk("lock_b1_haddr", HADDR, 32'h204);
    chk("lock_b1_m0_hready", M0_HREADY, 0);
    chk("lock_b1_m1_hready", M1_HREADY, 1);
    drv(0, TN, 32'h80, 0, 0, TB, 32'h208, 0, 0, 1, 0);
    chk("lock_busy_htrans", HTRANS, TB);
    chk("lock_busy_haddr", HADDR, 32'h208);
    chk("lock_busy_m0_hready", M0_HREADY, 0);
    drv(0, TN, 32'h80, 0, 0, TS, 32'h208, 0, 0, 1, 0);
    chk("lock_b2_htrans", HTRANS, TS);
    chk("lock_b2_haddr", HADDR, 32'h208);
    chk("lock_b2_m0_hready", M0_HREADY, 0);
    chk("lock_b2_m1_hready", M1_HREADY, 1);
    drv(0, TN, 32'h80, 0, 0, TS, 32'h20C, 0, 0, 1, 0);
    chk("lock_b3_haddr", HADDR, 32'h20C);
    chk("lock_b3_m0_hready", M0_HREADY, 0);
    drv(0, TN, 32'h80, 0, 0, TI, 32'h0, 0, 0, 1, 0);
    chk("unlock_haddr", HADDR, 32'h80);
    chk("unlock_m0_hready", M0_HREADY, 1);
    chk("unlock_m1_hready", M1_HREADY, 1);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 0);
    chk("unlock_idle_m0_hready", M0_HREADY, 1);

    // deferred completion of an M1 read
    drv(0, TI, 32'h0, 0, 0, TN, 32'h300, 0, 0, 1, 0);
    chk("defer_a_m1_hready", M1_HREADY, 1);
    rdq.push_back(32'hCAFE0001);
    drv(0, TN, 32'h90, 0, 0, TN, 32'h304, 0, 0, 1, 32'hCAFE0001);
    chk("defer_m1_hidden", M1_HREADY, 0);
    chk("defer_haddr_m0", HADDR, 32'h90);
    chk("defer_m0_hready", M0_HREADY, 1);
    rdq.push_back(32'hD0000090);
    drv(0, TI, 32'h0, 0, 0, TN, 32'h304, 0, 0, 1, 32'hD0000090);
    chk("defer_release_m1_hready", M1_HREADY, 1);
    chk("defer_release_haddr", HADDR, 32'h304);
    chk_pop("defer_m1_hrdata_held", M1_HRDATA);
    chk_pop("defer_m0_hrdata", M0_HRDATA);
    rdq.push_back(32'hE0000304);
    drv(0, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 32'hE0000304);
    chk_pop("defer_after_m1_hrdata", M1_HRDATA);
    chk("defer_after_m1_hready", M1_HREADY, 1);

    // back-to-back singles from both masters with one bus wait state
    m_ao = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      rdy = (c != 3);
      drv(0, TN, 32'h1000, 0, 0, TN, 32'h2000, 0, 0, rdy, 0);
      exp_nxt = RR ? ~m_ao : 1'b0;
      chk($sformatf("b2b_haddr_c%0d", c), HADDR, exp_nxt ? 32'h2000 : 32'h1000);
      if (c == 3) begin
        chk("b2b_stall_m0_hready", M0_HREADY, 0);
        chk("b2b_stall_m1_hready", M1_HREADY, 0);
      end
`ifndef AHBL_MUX_RR_EN
      chk($sformatf("b2b_m0_hready_c%0d", c), M0_HREADY, {31'b0, rdy});
      chk($sformatf("b2b_m1_hready_c%0d", c), M1_HREADY, 0);
`endif
      if (rdy) m_ao = exp_nxt;
    end
    drv(0, TI, 32'h0, 0, 0, TI, 32'h0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
